ram_param: RTL
==============

// Module: ram_param
// PURPOSE
//   Parametrised single-port synchronous RAM; successor to the fixed 8x16 RAM.
//   Adds configurable width and depth, a registered read with a valid strobe,
//   and a hardware clear sequencer that zero-fills the array after reset or on request.
//   Used as the generic storage element for register-file and memory assignments.
// PARAMETERS
//   WIDTH   16  data word width in bits
//   DEPTH   8   number of words; need not be a power of two
//   ADDR_W  3   address width; must satisfy 2**ADDR_W >= DEPTH
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   clear      in   1       one-cycle request to zero-fill the whole array
//   load       in   1       write enable
//   rd_en      in   1       read request
//   addr       in   ADDR_W  word address for read and write
//   inp        in   WIDTH   write data
//   out        out  WIDTH   registered read data
//   out_valid  out  1       pulses high for one cycle when out is updated by a read
//   busy       out  1       high while the clear sweep runs; load and rd_en are ignored
//   addr_err   out  1       pulses high for one cycle on load/rd_en with addr >= DEPTH
// BEHAVIOUR
//   Reset (rst_n=0, async): out=0, out_valid=0, addr_err=0, busy=1, FSM=CLEAR, sweep ptr=0.
//     The array itself is not reset. The sweep zero-fills it after rst_n releases.
//   FSM states: CLEAR and IDLE.
//     CLEAR: each edge writes 0 to mem[ptr] and then increments ptr.
//       After the edge that writes ptr=DEPTH-1, the FSM goes to IDLE.
//       busy is low DEPTH edges after rst_n releases.
//       clear=1 while in CLEAR restarts the sweep: ptr=0 on that edge, and that edge writes mem[0].
//     IDLE: clear=1 goes to CLEAR with ptr=0. No array write occurs on that edge.
//       clear has priority over load and rd_en on the same edge; both are dropped.
//   busy is driven combinationally: busy = (state == CLEAR).
//   While busy, load and rd_en have no effect. out holds its value. out_valid=0 and addr_err=0.
//   Write (IDLE, load=1, addr<DEPTH): mem[addr] takes inp on the rising edge.
//   Read (IDLE, rd_en=1, addr<DEPTH): out takes mem[addr] on the edge, so latency is 1 cycle.
//     out_valid=1 for exactly that following cycle.
//     Back-to-back reads give a result every cycle.
//   When no read occurs, out holds its last value and out_valid=0.
//   Same-edge load and rd_en to the same addr are read-first: out gets the old word.
//     The new word is visible to the next read.
//   Out-of-range (addr >= DEPTH, only when DEPTH < 2**ADDR_W):
//     The write is dropped.
//     A read loads out=0 and still pulses out_valid.
//     addr_err pulses for one cycle, registered like out_valid.
//   rst_n asserted mid-sweep or mid-read: all outputs return to reset values immediately.
//     The sweep restarts from ptr=0 after release.
//   Sweep ptr width is ADDR_W. ptr never passes DEPTH-1, so there is no wrap.
// TESTING
//   1. Release rst_n and count edges until busy falls.
//      busy=1 for exactly DEPTH edges (8). Reading all addresses then returns 0.
//   2. Write 0xA5A5 to addr 3, then rd_en addr 3 on the next cycle.
//      out=0xA5A5 and out_valid=1 one cycle after the read edge. out_valid is 0 the cycle after.
//   3. Store 0x1111 at addr 5. Then on one edge apply load=1, rd_en=1, addr=5, inp=0x2222.
//      out=0x1111. A following read returns 0x2222.
//   4. In IDLE, fill addrs 0-7 with non-zero data. Pulse clear together with load to addr 2.
//      The write is dropped and busy=1 for 8 cycles. All words then read 0.
//   5. Pulse clear again at sweep ptr=4. The sweep restarts and busy stays high 8 more edges.
//      Assert rst_n=0 mid-sweep: out=0 and busy=1 asynchronously.
//   6. Build DEPTH=6, ADDR_W=3. Write to addr 7, then read addr 7.
//      addr_err pulses on both. The read gives out=0 with out_valid=1. No valid word changes.

Source files
------------

// File: rtl/ram_param.sv
// ram_param
//   Parametrised single-port synchronous RAM with a registered read and a
//   hardware zero-fill sequencer. After reset, or when clear is pulsed, the
//   array is swept from word 0 to word DEPTH-1 writing zeros. During the sweep
//   busy is high and load/rd_en are ignored.
//
// Parameters
//   WIDTH   data word width in bits
//   DEPTH   number of words (need not be a power of two)
//   ADDR_W  address width, 2**ADDR_W >= DEPTH
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      one-cycle request to zero-fill the whole array
//   load       write enable
//   rd_en      read request
//   addr       word address for read and write
//   inp        write data
//   out        registered read data
//   out_valid  one-cycle strobe, out was updated by a read
//   busy       high while the clear sweep runs
//   addr_err   one-cycle strobe, load/rd_en used an address >= DEPTH
//
// state    | meaning
// ST_CLEAR | zero-fill sweep in progress, mem[ptr] <= 0 each edge
// ST_IDLE  | normal read/write operation

module ram_param #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  inp,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid,
    output logic              busy,
    output logic              addr_err
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam int              LAST_I   = DEPTH - 1;
    localparam logic [ADDR_W-1:0] LAST_PTR = LAST_I[ADDR_W-1:0];
    localparam logic [ADDR_W:0]   DEPTH_W  = DEPTH[ADDR_W:0];

    // Storage array; deliberately not reset, the sweep initialises it.
    logic [WIDTH-1:0] mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              addr_err_q, addr_err_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              addr_ok;

    // Extra leading zero keeps the compare correct when DEPTH == 2**ADDR_W.
    assign addr_ok = ({1'b0, addr} < DEPTH_W);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        addr_err_d  = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = addr;
        mem_wdata   = inp;

        unique case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_wdata = '0;
                if (clear) begin
                    // Restart: this edge zeroes word 0 and the full sweep
                    // then runs again from ptr 0.
                    mem_waddr = '0;
                    ptr_d     = '0;
                end else begin
                    mem_waddr = ptr_q;
                    if (ptr_q == LAST_PTR) begin
                        ptr_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end

            ST_IDLE: begin
                if (clear) begin
                    // clear wins over load/rd_en; both are dropped.
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end else begin
                    if (load && addr_ok) begin
                        mem_we = 1'b1;
                    end
                    if (rd_en) begin
                        out_valid_d = 1'b1;
                        // mem_q is sampled before the write lands: read-first.
                        out_d = addr_ok ? mem_q[addr] : '0;
                    end
                    addr_err_d = (load || rd_en) && !addr_ok;
                end
            end

            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            ptr_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            addr_err_q  <= addr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign addr_err  = addr_err_q;
    assign busy      = (state_q == ST_CLEAR);

endmodule
